// File: rtl/cpu_lsu.sv
// Load/store unit: turns one CPU load/store request into one or two aligned bus
// beats, splitting accesses that cross a bus word and merging/extending load data.
module cpu_lsu #(
  parameter int XLEN             = 32,
  parameter int ADDR_W           = 32,
  parameter int ALLOW_MISALIGNED = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  output logic              resp_valid_o,
  output logic [XLEN-1:0]   resp_rdata_o,
  output logic              resp_err_o,
  output logic              mem_enable_o,
  output logic [XLEN/8-1:0] mem_wstrb_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [XLEN-1:0]   mem_wvalue_o,
  input  logic [XLEN-1:0]   mem_rvalue_i,
  input  logic              mem_ready_i
);

  localparam int                B         = XLEN / 8;
  localparam int                SW        = 2 * B;
  localparam int                OFF_W     = $clog2(B);
  localparam logic [1:0]        SZ_MAX    = 2'(OFF_W);
  localparam logic [4:0]        B_BYTES   = 5'(B);
  localparam logic [ADDR_W-1:0] BEAT_STEP = ADDR_W'(B);
  localparam logic [ADDR_W-1:0] BASE_MASK = ~(ADDR_W'(B - 1));

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT0 = 2'd1,
    S_BEAT1 = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_req_ready;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [OFF_W-1:0]  r_off;
  logic              r_cross;
  logic [B-1:0]      r_strb_hi;
  logic [XLEN-1:0]   r_wv_hi;
  logic [XLEN-1:0]   r_raw0;
  logic              r_mem_enable;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [B-1:0]      r_mem_wstrb;
  logic [XLEN-1:0]   r_mem_wvalue;
  logic              r_resp_valid;
  logic [XLEN-1:0]   r_resp_rdata;
  logic              r_resp_err;

  logic [OFF_W-1:0]  w_off;
  logic [3:0]        w_nbytes;
  logic [4:0]        w_end;
  logic              w_cross;
  logic              w_misalign;
  logic              w_err;
  logic [8:0]        w_nmask;
  logic [SW-1:0]     w_strb_wide;
  logic [2*XLEN-1:0] w_wdata_wide;
  logic [XLEN-1:0]   w_rlow;
  logic [XLEN-1:0]   w_rhigh;
  logic [XLEN-1:0]   w_rjoin;
  logic [XLEN-1:0]   w_rload;

  state_t            w_state_nxt;
  logic              w_we_nxt;
  logic [1:0]        w_size_nxt;
  logic              w_uns_nxt;
  logic [OFF_W-1:0]  w_off_nxt;
  logic              w_cross_nxt;
  logic [B-1:0]      w_strb_hi_nxt;
  logic [XLEN-1:0]   w_wv_hi_nxt;
  logic [XLEN-1:0]   w_raw0_nxt;
  logic              w_en_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [B-1:0]      w_strb_nxt;
  logic [XLEN-1:0]   w_wv_nxt;
  logic              w_rvalid_nxt;
  logic [XLEN-1:0]   w_rdata_nxt;
  logic              w_rerr_nxt;

  function automatic logic [XLEN-1:0] f_extend(input logic [XLEN-1:0] d,
                                                input logic [1:0]      sz,
                                                input logic            uns);
    logic [XLEN-1:0] keep;
    logic            sb;
    case (sz)
      2'd0:    begin keep = XLEN'(8'hFF);         sb = d[7];      end
      2'd1:    begin keep = XLEN'(16'hFFFF);      sb = d[15];     end
      2'd2:    begin keep = XLEN'(32'hFFFF_FFFF); sb = d[31];     end
      default: begin keep = {XLEN{1'b1}};         sb = d[XLEN-1]; end
    endcase
    return (d & keep) | ({XLEN{sb & ~uns}} & ~keep);
  endfunction

  // Request decode and load-data merge
  always_comb begin
    w_off        = req_addr_i[OFF_W-1:0];
    w_nbytes     = 4'd1 << req_size_i;
    w_end        = 5'(w_off) + {1'b0, w_nbytes};
    w_cross      = (w_end > B_BYTES);
    w_misalign   = ((req_addr_i[2:0] & 3'(w_nbytes - 4'd1)) != 3'd0);
    w_err        = (req_size_i > SZ_MAX) || ((ALLOW_MISALIGNED == 0) && w_misalign);
    w_nmask      = (9'd1 << w_nbytes) - 9'd1;
    // Lower half of the wide vectors feeds beat 0, upper half feeds beat 1.
    w_strb_wide  = SW'(w_nmask) << w_off;
    w_wdata_wide = {{XLEN{1'b0}}, req_wdata_i} << {w_off, 3'b000};
    w_rlow       = (r_state == S_BEAT0) ? mem_rvalue_i : r_raw0;
    w_rhigh      = (r_state == S_BEAT1) ? mem_rvalue_i : {XLEN{1'b0}};
    w_rjoin      = XLEN'({w_rhigh, w_rlow} >> {r_off, 3'b000});
    w_rload      = f_extend(w_rjoin, r_size, r_unsigned);
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt   = r_state;
    w_we_nxt      = r_we;
    w_size_nxt    = r_size;
    w_uns_nxt     = r_unsigned;
    w_off_nxt     = r_off;
    w_cross_nxt   = r_cross;
    w_strb_hi_nxt = r_strb_hi;
    w_wv_hi_nxt   = r_wv_hi;
    w_raw0_nxt    = r_raw0;
    w_en_nxt      = r_mem_enable;
    w_addr_nxt    = r_mem_addr;
    w_strb_nxt    = r_mem_wstrb;
    w_wv_nxt      = r_mem_wvalue;
    w_rvalid_nxt  = 1'b0;
    w_rdata_nxt   = {XLEN{1'b0}};
    w_rerr_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid_i) begin
          w_we_nxt      = req_we_i;
          w_size_nxt    = req_size_i;
          w_uns_nxt     = req_unsigned_i;
          w_off_nxt     = w_off;
          w_cross_nxt   = w_cross;
          w_strb_hi_nxt = req_we_i ? w_strb_wide[SW-1:B] : {B{1'b0}};
          w_wv_hi_nxt   = w_wdata_wide[2*XLEN-1:XLEN];
          w_raw0_nxt    = {XLEN{1'b0}};
          if (w_err) begin
            w_state_nxt  = S_RESP;
            w_rvalid_nxt = 1'b1;
            w_rerr_nxt   = 1'b1;
          end else begin
            w_state_nxt  = S_BEAT0;
            w_en_nxt     = 1'b1;
            w_addr_nxt   = req_addr_i & BASE_MASK;
            w_strb_nxt   = req_we_i ? w_strb_wide[B-1:0] : {B{1'b0}};
            w_wv_nxt     = w_wdata_wide[XLEN-1:0];
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BEAT0: begin
        if (mem_ready_i) begin
          w_raw0_nxt = mem_rvalue_i;
          if (r_cross) begin
            w_state_nxt = S_BEAT1;
            w_addr_nxt  = r_mem_addr + BEAT_STEP;
            w_strb_nxt  = r_strb_hi;
            w_wv_nxt    = r_wv_hi;
          end else begin
            w_state_nxt  = S_RESP;
            w_en_nxt     = 1'b0;
            w_addr_nxt   = {ADDR_W{1'b0}};
            w_strb_nxt   = {B{1'b0}};
            w_wv_nxt     = {XLEN{1'b0}};
            w_rvalid_nxt = 1'b1;
            w_rdata_nxt  = r_we ? {XLEN{1'b0}} : w_rload;
          end
        end else begin
          w_state_nxt = S_BEAT0;
        end
      end
      S_BEAT1: begin
        if (mem_ready_i) begin
          w_state_nxt  = S_RESP;
          w_en_nxt     = 1'b0;
          w_addr_nxt   = {ADDR_W{1'b0}};
          w_strb_nxt   = {B{1'b0}};
          w_wv_nxt     = {XLEN{1'b0}};
          w_rvalid_nxt = 1'b1;
          w_rdata_nxt  = r_we ? {XLEN{1'b0}} : w_rload;
        end else begin
          w_state_nxt = S_BEAT1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_en_nxt    = 1'b0;
      end
    endcase
  end

  // State, captured request fields and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_we         <= 1'b0;
      r_size       <= 2'd0;
      r_unsigned   <= 1'b0;
      r_off        <= {OFF_W{1'b0}};
      r_cross      <= 1'b0;
      r_strb_hi    <= {B{1'b0}};
      r_wv_hi      <= {XLEN{1'b0}};
      r_raw0       <= {XLEN{1'b0}};
      r_mem_enable <= 1'b0;
      r_mem_addr   <= {ADDR_W{1'b0}};
      r_mem_wstrb  <= {B{1'b0}};
      r_mem_wvalue <= {XLEN{1'b0}};
      r_resp_valid <= 1'b0;
      r_resp_rdata <= {XLEN{1'b0}};
      r_resp_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_req_ready  <= (w_state_nxt == S_IDLE);
      r_we         <= w_we_nxt;
      r_size       <= w_size_nxt;
      r_unsigned   <= w_uns_nxt;
      r_off        <= w_off_nxt;
      r_cross      <= w_cross_nxt;
      r_strb_hi    <= w_strb_hi_nxt;
      r_wv_hi      <= w_wv_hi_nxt;
      r_raw0       <= w_raw0_nxt;
      r_mem_enable <= w_en_nxt;
      r_mem_addr   <= w_addr_nxt;
      r_mem_wstrb  <= w_strb_nxt;
      r_mem_wvalue <= w_wv_nxt;
      r_resp_valid <= w_rvalid_nxt;
      r_resp_rdata <= w_rdata_nxt;
      r_resp_err   <= w_rerr_nxt;
    end
  end

  assign req_ready_o  = r_req_ready;
  assign mem_enable_o = r_mem_enable;
  assign mem_addr_o   = r_mem_addr;
  assign mem_wstrb_o  = r_mem_wstrb;
  assign mem_wvalue_o = r_mem_wvalue;
  assign resp_valid_o = r_resp_valid;
  assign resp_rdata_o = r_resp_rdata;
  assign resp_err_o   = r_resp_err;

endmodule

// File: tb/tb_cpu_lsu.sv
// Directed self-checking bench for cpu_lsu: one instance with misaligned splitting,
// one with misaligned accesses reported as errors.
module tb_cpu_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_valid_na = 1'b0;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_uns = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        mem_ready = 1'b1;

  logic        req_ready, resp_valid, resp_err, mem_en;
  logic [31:0] resp_rdata, mem_addr, mem_wvalue, mem_rvalue;
  logic [3:0]  mem_wstrb;

  logic        na_ready, na_rvalid, na_err, na_en;
  logic [31:0] na_rdata, na_addr, na_wvalue, na_rvalue;
  logic [3:0]  na_wstrb;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] f_mem(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h4433_2211;
      32'h0000_0104: return 32'h8877_6655;
      32'h0000_0000: return 32'h0080_FF00;
      default:       return 32'h0000_0000;
    endcase
  endfunction

  assign mem_rvalue = f_mem(mem_addr);
  assign na_rvalue  = f_mem(na_addr);

  cpu_lsu #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_uns), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .mem_enable_o(mem_en), .mem_wstrb_o(mem_wstrb), .mem_addr_o(mem_addr),
    .mem_wvalue_o(mem_wvalue), .mem_rvalue_i(mem_rvalue), .mem_ready_i(mem_ready)
  );

  cpu_lsu #(.XLEN(32), .ADDR_W(32), .ALLOW_MISALIGNED(0)) dut_na (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_na), .req_ready_o(na_ready), .req_we_i(req_we),
    .req_size_i(req_size), .req_unsigned_i(req_uns), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata),
    .resp_valid_o(na_rvalid), .resp_rdata_o(na_rdata), .resp_err_o(na_err),
    .mem_enable_o(na_en), .mem_wstrb_o(na_wstrb), .mem_addr_o(na_addr),
    .mem_wvalue_o(na_wvalue), .mem_rvalue_i(na_rvalue), .mem_ready_i(mem_ready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
    req_we    = we;
    req_size  = sz;
    req_uns   = uns;
    req_addr  = a;
    req_wdata = wd;
  endtask

  initial begin
    // reset state
    step();
    step();
    chk("rst_ready", req_ready, 1);
    chk("rst_en", mem_en, 0);
    chk("rst_strb", mem_wstrb, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wvalue", mem_wvalue, 0);
    chk("rst_rvalid", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", resp_err, 0);
    rst_i = 1'b0;

    // store word 0xDEADBEEF at 0x100
    set_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF);
    req_valid = 1'b1;
    chk("sw_ready_idle", req_ready, 1);
    step();
    req_valid = 1'b0;
    chk("sw_b0_en", mem_en, 1);
    chk("sw_b0_addr", mem_addr, 32'h100);
    chk("sw_b0_strb", mem_wstrb, 4'b1111);
    chk("sw_b0_wvalue", mem_wvalue, 32'hDEAD_BEEF);
    chk("sw_b0_rvalid", resp_valid, 0);
    step();
    chk("sw_resp_valid", resp_valid, 1);
    chk("sw_resp_rdata", resp_rdata, 0);
    chk("sw_resp_err", resp_err, 0);
    chk("sw_resp_en", mem_en, 0);
    step();
    chk("sw_idle_rvalid", resp_valid, 0);
    chk("sw_idle_ready", req_ready, 1);

    // store byte 0xA5 at 0x103
    set_req(1'b1, 2'd0, 1'b0, 32'h103, 32'h0000_00A5);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("sb_addr", mem_addr, 32'h100);
    chk("sb_strb", mem_wstrb, 4'b1000);
    chk("sb_wvalue", mem_wvalue, 32'hA500_0000);
    step();
    chk("sb_resp_valid", resp_valid, 1);
    step();

    // misaligned load word at 0x102, split into two beats
    set_req(1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("lw_b0_en", mem_en, 1);
    chk("lw_b0_addr", mem_addr, 32'h100);
    chk("lw_b0_strb", mem_wstrb, 4'b0000);
    step();
    chk("lw_b1_en", mem_en, 1);
    chk("lw_b1_addr", mem_addr, 32'h104);
    chk("lw_b1_strb", mem_wstrb, 4'b0000);
    chk("lw_b1_rvalid", resp_valid, 0);
    step();
    chk("lw_resp_valid", resp_valid, 1);
    chk("lw_resp_rdata", resp_rdata, 32'h6655_4433);
    chk("lw_resp_err", resp_err, 0);
    step();
    chk("lw_idle_rvalid", resp_valid, 0);

    // signed half load at 0x001; a request during the beat must be ignored
    set_req(1'b0, 2'd1, 1'b0, 32'h001, 32'h0);
    req_valid = 1'b1;
    step();
    chk("lh_b0_addr", mem_addr, 32'h0);
    chk("lh_b0_ready", req_ready, 0);
    set_req(1'b1, 2'd2, 1'b0, 32'h200, 32'h1234_5678);
    step();
    req_valid = 1'b0;
    chk("lh_resp_valid", resp_valid, 1);
    chk("lh_resp_rdata", resp_rdata, 32'hFFFF_80FF);
    step();
    chk("lh_no_queue_en", mem_en, 0);
    chk("lh_no_queue_rvalid", resp_valid, 0);

    // unsigned half load at 0x001
    set_req(1'b0, 2'd1, 1'b1, 32'h001, 32'h0);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    chk("lhu_resp_valid", resp_valid, 1);
    chk("lhu_resp_rdata", resp_rdata, 32'h0000_80FF);
    step();

    // misaligned word load with splitting disabled -> error, no bus access
    set_req(1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
    req_valid_na = 1'b1;
    chk("na_idle_en", na_en, 0);
    step();
    req_valid_na = 1'b0;
    chk("na_mis_en", na_en, 0);
    chk("na_mis_rvalid", na_rvalid, 1);
    chk("na_mis_err", na_err, 1);
    chk("na_mis_rdata", na_rdata, 0);
    step();
    chk("na_mis_after_rvalid", na_rvalid, 0);
    chk("na_mis_after_en", na_en, 0);

    // dword access on a 32-bit bus -> error on both instances
    set_req(1'b0, 2'd3, 1'b0, 32'h100, 32'h0);
    req_valid_na = 1'b1;
    req_valid = 1'b1;
    step();
    req_valid_na = 1'b0;
    req_valid = 1'b0;
    chk("na_d_en", na_en, 0);
    chk("na_d_err", na_err, 1);
    chk("na_d_rvalid", na_rvalid, 1);
    chk("d_en", mem_en, 0);
    chk("d_err", resp_err, 1);
    chk("d_rvalid", resp_valid, 1);
    chk("d_rdata", resp_rdata, 0);
    step();

    // wrapping store word at 0xFFFFFFFE with wait states, reset during beat 1
    set_req(1'b1, 2'd2, 1'b0, 32'hFFFF_FFFE, 32'h1122_3344);
    mem_ready = 1'b0;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) mem_ready = 1'b1;
      chk("wr_b0_en", mem_en, 1);
      chk("wr_b0_addr", mem_addr, 32'hFFFF_FFFC);
      chk("wr_b0_strb", mem_wstrb, 4'b1100);
      chk("wr_b0_wvalue", mem_wvalue, 32'h3344_0000);
      if (k < 3) step();
    end
    step();
    mem_ready = 1'b0;
    chk("wr_b1_en", mem_en, 1);
    chk("wr_b1_addr", mem_addr, 32'h0000_0000);
    chk("wr_b1_strb", mem_wstrb, 4'b0011);
    chk("wr_b1_wvalue", mem_wvalue, 32'h0000_1122);
    step();
    chk("wr_b1_hold_strb", mem_wstrb, 4'b0011);
    chk("wr_b1_hold_rvalid", resp_valid, 0);
    #2;
    rst_i = 1'b1;
    #1;
    chk("ab_en", mem_en, 0);
    chk("ab_ready", req_ready, 1);
    chk("ab_rvalid", resp_valid, 0);
    chk("ab_strb", mem_wstrb, 0);
    mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("ab_hold_rvalid", resp_valid, 0);
    end
    rst_i = 1'b0;

    // first request after reset accepted on the first edge
    set_req(1'b1, 2'd0, 1'b0, 32'h101, 32'h0000_005A);
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("pr_en", mem_en, 1);
    chk("pr_addr", mem_addr, 32'h100);
    chk("pr_strb", mem_wstrb, 4'b0010);
    chk("pr_wvalue", mem_wvalue, 32'h0000_5A00);
    step();
    chk("pr_resp_valid", resp_valid, 1);
    step();
    chk("pr_idle_rvalid", resp_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
